// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 keypad scanner. Debounces presses and releases and
// emits one {row,col} key code per press with a single-cycle strobe.
module matrix_key_scan #(
  parameter int unsigned SCAN_DIV       = 24999,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] KEY_Value,
  output logic       Value_en
);

  localparam int unsigned DIV_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_SCAN     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_s;
  logic [DIV_W-1:0] r_div_cnt;
  state_t           r_state;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row;
  logic [3:0]       r_key;
  logic             r_en;

  logic             w_tick;
  logic             w_any_low;
  logic [1:0]       w_col_idx;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_deb_nxt;
  logic [CNT_W-1:0] w_rel_nxt;
  logic [1:0]       w_row_idx_nxt;
  logic [3:0]       w_key_nxt;
  logic             w_en_nxt;
  logic [3:0]       w_row_nxt;

  assign ROW       = r_row;
  assign KEY_Value = r_key;
  assign Value_en  = r_en;

  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_any_low = (r_col_s != 4'b1111);

  // Column synchronizer; idles at all-high (no key)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_col_meta <= 4'b1111;
      r_col_s    <= 4'b1111;
    end else begin
      r_col_meta <= COL;
      r_col_s    <= r_col_meta;
    end
  end

  // Free-running scan-tick divider
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Lowest-index low column wins
  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_col_s[i]) w_col_idx = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_nxt     = r_deb_cnt;
    w_rel_nxt     = r_rel_cnt;
    w_row_idx_nxt = r_row_idx;
    w_key_nxt     = r_key;
    w_en_nxt      = 1'b0;
    w_row_nxt     = 4'b0000;

    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_any_low) begin
            w_state_nxt = S_DEBOUNCE;
            w_deb_nxt   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (!w_any_low) begin
            w_state_nxt = S_IDLE;
          end else if (r_deb_cnt == CNT_LAST) begin
            w_state_nxt   = S_SCAN;
            w_row_idx_nxt = 2'd0;
          end else begin
            w_deb_nxt = r_deb_cnt + CNT_W'(1);
          end
        end
        S_SCAN: begin
          if (w_any_low) begin
            w_key_nxt   = {r_row_idx, w_col_idx};
            w_en_nxt    = 1'b1;
            w_rel_nxt   = '0;
            w_state_nxt = S_HOLD;
          end else if (r_row_idx == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
        S_HOLD: begin
          // Any low column restarts the release debounce
          if (w_any_low) begin
            w_rel_nxt = '0;
          end else if (r_rel_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rel_nxt = r_rel_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_state_nxt == S_SCAN) begin
      w_row_nxt = ~(4'b0001 << w_row_idx_nxt);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_rel_cnt <= '0;
      r_row_idx <= 2'd0;
      r_row     <= 4'b0000;
      r_key     <= 4'h0;
      r_en      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_rel_cnt <= w_rel_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_row     <= w_row_nxt;
      r_key     <= w_key_nxt;
      r_en      <= w_en_nxt;
    end
  end

endmodule

// File: tb/tb_matrix_key_scan.sv
// tb_matrix_key_scan: directed press/release vectors against a behavioural
// 4x4 keypad model, plus glitch, bounce and reset corner sequences.
module tb_matrix_key_scan;

  localparam int unsigned SCAN_DIV = 9;
  localparam int unsigned DEB      = 3;
  localparam int unsigned TICK     = SCAN_DIV + 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  COL;
  logic [3:0]  ROW;
  logic [3:0]  KEY_Value;
  logic        Value_en;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int bad_row = 0;
  int long_en = 0;
  logic prev_en = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    int          row;
  } vec_t;

  vec_t vecs[7];

  always #5 CLK = ~CLK;

  matrix_key_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .COL      (COL),
    .ROW      (ROW),
    .KEY_Value(KEY_Value),
    .Value_en (Value_en)
  );

  // Keypad: column c pulled low when a closed key sits on a driven row
  always_comb begin
    COL = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !ROW[r]) COL[c] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (Value_en) strobe_cnt++;
      if (Value_en && prev_en) long_en++;
      if (!(ROW inside {4'b0000, 4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_row++;
    end
    prev_en = Value_en;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_strobe(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!Value_en && n < 200);
    chk({name, "_strobe_seen"}, int'(Value_en), 1);
  endtask

  initial begin
    int n;
    int s0;
    int lo;
    int hi;

    vecs[0] = '{keys: 16'h0200, code: 4'h9, row: 2};  // (2,1)
    vecs[1] = '{keys: 16'h8004, code: 4'h2, row: 0};  // (3,3)+(0,2)
    vecs[2] = '{keys: 16'h0001, code: 4'h0, row: 0};  // (0,0)
    vecs[3] = '{keys: 16'h1000, code: 4'hC, row: 3};  // (3,0)
    vecs[4] = '{keys: 16'h00C0, code: 4'h6, row: 1};  // (1,2)+(1,3)
    vecs[5] = '{keys: 16'h8000, code: 4'hF, row: 3};  // (3,3)
    vecs[6] = '{keys: 16'h2800, code: 4'hB, row: 2};  // (2,3)+(3,1)

    repeat (3) step();
    chk("rst_row", int'(ROW), 0);
    chk("rst_key", int'(KEY_Value), 0);
    chk("rst_en", int'(Value_en), 0);
    RST = 1'b0;

    // Idle with no keys
    repeat (500) step();
    chk("idle_strobes", strobe_cnt, 0);
    chk("idle_key", int'(KEY_Value), 0);
    chk("idle_row", int'(ROW), 0);
    chk("idle_bad_row", bad_row, 0);

    // Glitch on (1,0) shorter than the debounce window
    s0 = strobe_cnt;
    keys = 16'h0010;
    repeat (15) step();
    keys = 16'h0000;
    repeat (100) step();
    chk("glitch_strobes", strobe_cnt - s0, 0);

    for (int i = 0; i < 7; i++) begin
      s0 = strobe_cnt;
      keys = vecs[i].keys;
      wait_strobe($sformatf("vec%0d", i), n);
      lo = 3 + int'(DEB * TICK) + (vecs[i].row + 1) * int'(TICK);
      hi = 2 + int'(TICK) + int'(DEB * TICK) + (vecs[i].row + 1) * int'(TICK) + 1;
      chk_range($sformatf("vec%0d_latency", i), n, lo, hi);
      chk($sformatf("vec%0d_code", i), int'(KEY_Value), int'(vecs[i].code));
      repeat (200 - n) step();
      chk($sformatf("vec%0d_held_strobes", i), strobe_cnt - s0, 1);
      keys = 16'h0000;
      repeat (40) step();
      chk($sformatf("vec%0d_release_strobes", i), strobe_cnt - s0, 1);
      chk($sformatf("vec%0d_code_kept", i), int'(KEY_Value), int'(vecs[i].code));
    end

    // Hold (1,3) with one-tick release bounces every 100 cycles
    s0 = strobe_cnt;
    keys = 16'h0080;
    for (int k = 0; k < 10; k++) begin
      repeat (90) step();
      keys = 16'h0000;
      repeat (10) step();
      keys = 16'h0080;
    end
    keys = 16'h0000;
    repeat (40) step();
    chk("bounce_strobes", strobe_cnt - s0, 1);
    chk("bounce_code", int'(KEY_Value), 7);

    // Reset mid-HOLD with (0,0) still closed
    keys = 16'h0001;
    wait_strobe("hold_rst_first", n);
    repeat (30) step();
    s0 = strobe_cnt;
    RST = 1'b1;
    #1;
    chk("hold_rst_row", int'(ROW), 0);
    chk("hold_rst_en", int'(Value_en), 0);
    repeat (5) step();
    chk("hold_rst_key", int'(KEY_Value), 0);
    chk("hold_rst_en_held", int'(Value_en), 0);
    RST = 1'b0;
    wait_strobe("hold_rst_again", n);
    chk("hold_rst_latency", n, int'(TICK) + int'(DEB * TICK) + 1 * int'(TICK));
    chk("hold_rst_code", int'(KEY_Value), 0);
    chk("hold_rst_strobes", strobe_cnt - s0, 1);
    keys = 16'h0000;
    repeat (40) step();

    // Reset landing on the strobe cycle of (3,3)
    keys = 16'h8000;
    wait_strobe("en_rst_first", n);
    chk("en_rst_code_before", int'(KEY_Value), 15);
    RST = 1'b1;
    #1;
    chk("en_rst_en", int'(Value_en), 0);
    chk("en_rst_key", int'(KEY_Value), 0);
    chk("en_rst_row", int'(ROW), 0);
    repeat (5) step();
    RST = 1'b0;
    wait_strobe("en_rst_again", n);
    chk("en_rst_latency", n, int'(TICK) + int'(DEB * TICK) + 4 * int'(TICK));
    chk("en_rst_code", int'(KEY_Value), 15);
    keys = 16'h0000;
    repeat (40) step();

    chk("row_legal", bad_row, 0);
    chk("strobe_width", long_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_key_scan.md
# matrix_key_scan

Scans a 4x4 matrix keypad, debounces presses and releases, and emits one 4-bit key code per press with a single-cycle strobe. It is the producer side of the `KEY_Value`/`Value_en` interface consumed by the seven-segment display controller. It sits between the keypad pins and the display path.

## Interface
Parameters:
- `SCAN_DIV`, default 24999: scan-tick divider. One tick every `SCAN_DIV+1` CLK cycles (500 µs at 50 MHz).
- `DEBOUNCE_TICKS`, default 20: consecutive stable ticks required to accept a press or a release (10 ms at default).

Ports:
- `CLK`  in  1: system clock; single clock domain.
- `RST`  in  1: reset, asynchronous, active-high.
- `COL`  in  4: keypad column inputs, externally pulled up. Low means a key in a driven row is closed. Asynchronous to CLK.
- `ROW`  out  4: keypad row drive, active-low.
- `KEY_Value`  out  4: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `Value_en`  out  1: one-CLK strobe marking a new `KEY_Value`.

## Operation
- `COL` passes through a 2-FF synchronizer to give `COL_s`; all decisions use `COL_s`.
- Free-running divider `div_cnt` counts 0..`SCAN_DIV`. `tick` is high for the one CLK cycle where `div_cnt==SCAN_DIV`, and `div_cnt` then wraps to 0.
- FSM states and transitions are evaluated only on `tick` cycles.
  - IDLE:
    - `ROW=4'b0000`.
    - If `COL_s!=4'b1111`: go to DEBOUNCE and set `deb_cnt=0`.
  - DEBOUNCE:
    - `ROW=4'b0000`.
    - If `COL_s==4'b1111`: go to IDLE (bounce rejected).
    - Else if `deb_cnt==DEBOUNCE_TICKS-1`: go to SCAN with `row_idx=0`.
    - Else: `deb_cnt+1`.
  - SCAN:
    - `ROW=~(4'b0001<<row_idx)`. Each row is driven for one full tick before sampling.
    - If `COL_s!=4'b1111`: `col_idx` is the lowest-index zero bit. Register `KEY_Value={row_idx,col_idx}`, assert `Value_en`, set `rel_cnt=0`, go to HOLD.
    - Else if `row_idx==3`: go to IDLE (key vanished).
    - Else: `row_idx+1`.
  - HOLD:
    - `ROW=4'b0000`.
    - `COL_s==4'b1111` increments `rel_cnt`; any low column clears it to 0.
    - When `COL_s==4'b1111` and `rel_cnt==DEBOUNCE_TICKS-1`: go to IDLE.
    - No new code is issued while in HOLD, so holding a key never repeats.
- Multiple simultaneous keys: the first hit in scan order wins, i.e. lowest row, then lowest column.
- Key changes during HOLD (a second key added, or one key swapped for another without a full release) produce no new code until a full debounced release.
- `KEY_Value` holds its value until the next accepted press. `Value_en` is high for exactly one CLK cycle: the cycle after the SCAN-accept tick edge.
- Counter widths: `div_cnt` is `$clog2(SCAN_DIV+1)` bits. `deb_cnt` and `rel_cnt` are `$clog2(DEBOUNCE_TICKS)` bits minimum, and must never wrap.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `ROW=4'b0000`.
  - `KEY_Value=4'h0`, `Value_en=0`.
  - `div_cnt`, `deb_cnt`, `rel_cnt`, `row_idx` = 0; synchronizer flops = `4'b1111`.
- First `tick` occurs `SCAN_DIV+1` CLK cycles after `RST` deasserts.
- Press latency, from clean closure to the `Value_en` rise:
  - 2 CLK synchronizer, plus at most 1 tick to detect,
  - plus `DEBOUNCE_TICKS` ticks,
  - plus `row_idx+1` ticks of scanning,
  - plus 1 CLK.
- Release latency: `DEBOUNCE_TICKS` ticks of continuous `COL_s==4'b1111` after the release reaches `COL_s`.
- `ROW` changes only on the CLK edge following a `tick`.
- `RST` asserted in any state, including mid-HOLD or during the `Value_en` cycle, forces reset values immediately. No strobe may be emitted after reset until a fresh full debounce completes.

## Test plan
Bench parameters: `SCAN_DIV=9`, `DEBOUNCE_TICKS=3`. The keypad model drives `COL[c]=0` iff key (r,c) is closed and `ROW[r]==0`.
- Reset then idle 500 CLK with no keys -> `ROW` stays `4'b0000`, `Value_en` never asserts, `KEY_Value=4'h0`.
- Close key (2,1) clean for 200 CLK, then release -> exactly one `Value_en` pulse with `KEY_Value=4'h9`, rise within 2+10+30+30+1 CLK of closure; return to IDLE 30 CLK after release.
- Close (3,3), then (0,2) simultaneously -> single strobe, `KEY_Value=4'h2`; `4'hF` is never reported.
- Glitch key (1,0) for 15 CLK (under 3 ticks) -> no `Value_en`, FSM back in IDLE.
- Hold (1,3) for 1000 CLK with 1-tick release bounces every 100 CLK -> one strobe only, `KEY_Value=4'h7`.
- Assert `RST` mid-HOLD after (0,0) is accepted, keep the key closed, then deassert -> outputs at reset values during `RST`; after release from reset, a new strobe with `KEY_Value=4'h0` only after a full debounce.
